// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and
// multdiv results wait in a small FIFO that drains on idle pipeline cycles.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_reg,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  q_reg,
    output logic        q_pending,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          r_live [DEPTH];
    logic [4:0]    r_reg  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          r_we;
    logic [4:0]    r_wreg;
    logic [31:0]   r_wdata;

    logic          w_pipe_sel;
    logic          w_pop;
    logic          w_push;
    logic          w_push_live;
    logic          w_head_live;
    logic          w_q_hit;

    assign md_ready    = (r_count != CW'(DEPTH));
    assign w_pipe_sel  = pipe_valid & (pipe_reg != 5'd0);
    assign w_pop       = ~w_pipe_sel & (r_count != CW'(0));
    assign w_push      = md_valid & md_ready & (md_reg != 5'd0);
    // A same-cycle pipeline write to the same register is younger, so the md result is stale on arrival.
    assign w_push_live = ~(w_pipe_sel & (md_reg == pipe_reg));
    assign w_head_live = r_live[r_rd_ptr];

    // FIFO control: pointers, occupancy and live bits (live is cleared on pop so only queued entries match).
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_rd_ptr <= PW'(0);
            r_wr_ptr <= PW'(0);
            r_count  <= CW'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_live[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_pipe_sel && (r_reg[i] == pipe_reg)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
                r_live[r_wr_ptr] <= w_push_live;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; validity is tracked solely by the live bits.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_reg[r_wr_ptr]  <= md_reg;
            r_data[r_wr_ptr] <= md_data;
        end
    end

    // Registered write port; address/data hold when no write is selected.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_we    <= 1'b0;
            r_wreg  <= 5'd0;
            r_wdata <= 32'd0;
        end else if (w_pipe_sel) begin
            r_we    <= 1'b1;
            r_wreg  <= pipe_reg;
            r_wdata <= pipe_data;
        end else if (w_pop && w_head_live) begin
            r_we    <= 1'b1;
            r_wreg  <= r_reg[r_rd_ptr];
            r_wdata <= r_data[r_rd_ptr];
        end else begin
            r_we    <= 1'b0;
        end
    end

    always_comb begin
        w_q_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_live[i] && (r_reg[i] == q_reg)) begin
                w_q_hit = 1'b1;
            end
        end
    end

    assign q_pending        = w_q_hit & (q_reg != 5'd0);
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        pipe_valid;
    logic [4:0]  pipe_reg;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  q_reg;
    logic        q_pending;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_valid       (pipe_valid),
        .pipe_reg         (pipe_reg),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .q_reg            (q_reg),
        .q_pending        (q_pending),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
    );

    typedef struct {
        logic        live;
        logic [4:0]  rg;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        m_valid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_pending(input logic [4:0] r);
        logic hit = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].rg == r) hit = 1'b1;
        end
        return hit && (r != 5'd0);
    endfunction

    // One clock of the reference behaviour, using the inputs currently applied.
    task automatic model_update();
        ent_t h;
        logic sel;
        logic rdy;
        if (ctrl_reset) begin
            mq.delete();
            m_we   = 1'b0;
            m_reg  = 5'd0;
            m_data = 32'd0;
            m_valid = 1'b1;
            return;
        end
        sel = pipe_valid && (pipe_reg != 5'd0);
        rdy = (mq.size() < int'(DEPTH));
        if (sel) begin
            foreach (mq[i]) begin
                if (mq[i].rg == pipe_reg) mq[i].live = 1'b0;
            end
            m_we = 1'b1; m_reg = pipe_reg; m_data = pipe_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.live) begin
                m_we = 1'b1; m_reg = h.rg; m_data = h.d;
            end else begin
                m_we = 1'b0;
            end
        end else begin
            m_we = 1'b0;
        end
        if (md_valid && rdy && md_reg != 5'd0) begin
            h.live = !(sel && pipe_reg == md_reg);
            h.rg   = md_reg;
            h.d    = md_data;
            mq.push_back(h);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] mdd,
                         input logic [4:0] qr);
        pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
        md_valid = mv; md_reg = mr; md_data = mdd; q_reg = qr;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    // Check combinational outputs, advance one edge, then check the write port.
    task automatic step();
        #1;
        if (m_valid) begin
            chk("md_ready", 32'(md_ready), 32'(mq.size() < int'(DEPTH)));
            chk("q_pending", 32'(q_pending), 32'(m_pending(q_reg)));
        end
        model_update();
        @(posedge clock);
        #1;
        chk("we", 32'(ctrl_writeEnable), 32'(m_we));
        chk("wreg", 32'(ctrl_writeReg), 32'(m_reg));
        chk("wdata", data_writeReg, m_data);
    endtask

    task automatic check_pending(input logic [4:0] r, input logic exp, input string tag);
        q_reg = r;
        #1;
        chk(tag, 32'(q_pending), 32'(exp));
    endtask

    initial begin
        ctrl_reset = 1'b1;
        drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, 5'($urandom));
        @(negedge clock);

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom, 5'($urandom));
            step();
        end
        ctrl_reset = 1'b0;
        idle();
        chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
        chk("rst_wreg", 32'(ctrl_writeReg), 32'd0);
        chk("rst_wdata", data_writeReg, 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd1);
        for (int r = 0; r < 32; r++) check_pending(5'(r), 1'b0, "rst_q_pending");

        // Pipeline latency.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0);
        step();
        chk("pipe_lat_we", 32'(ctrl_writeEnable), 32'd1);
        chk("pipe_lat_reg", 32'(ctrl_writeReg), 32'd5);
        chk("pipe_lat_data", data_writeReg, 32'hDEADBEEF);
        idle();
        step();
        chk("pipe_lat_we_off", 32'(ctrl_writeEnable), 32'd0);

        // Priority and backpressure.
        drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd3, 32'h11, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h71, 1'b1, 5'd4, 32'h22, 5'd0);
        step();
        chk("bp_md_ready_full", 32'(md_ready), 32'd0);
        drive(1'b1, 5'd7, 32'h72, 1'b0, 5'd0, 32'd0, 5'd0);
        step();
        drive(1'b1, 5'd7, 32'h73, 1'b0, 5'd0, 32'd0, 5'd0);
        step();
        check_pending(5'd3, 1'b1, "bp_pending_r3");
        check_pending(5'd4, 1'b1, "bp_pending_r4");
        idle();
        step();
        chk("bp_drain1_reg", 32'(ctrl_writeReg), 32'd3);
        chk("bp_drain1_data", data_writeReg, 32'h11);
        step();
        chk("bp_drain2_reg", 32'(ctrl_writeReg), 32'd4);
        chk("bp_drain2_data", data_writeReg, 32'h22);
        chk("bp_md_ready_back", 32'(md_ready), 32'd1);

        // Squash of a queued result by a younger pipeline write.
        drive(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9, 32'h1, 5'd9);
        step();
        drive(1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'd0, 5'd9);
        step();
        check_pending(5'd9, 1'b1, "sq_pending_before");
        drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0, 5'd9);
        step();
        check_pending(5'd9, 1'b0, "sq_pending_after");
        chk("sq_final_data", data_writeReg, 32'h2);
        idle();
        step();
        chk("sq_dead_we", 32'(ctrl_writeEnable), 32'd0);

        // Same-cycle md and pipeline write to the same register.
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h99, 5'd6);
        step();
        chk("same_data", data_writeReg, 32'h66);
        idle();
        step();
        chk("same_dead_we", 32'(ctrl_writeEnable), 32'd0);
        step();
        chk("same_md_ready", 32'(md_ready), 32'd1);

        // $r0 filtering, and draining during a pipe_reg=0 cycle.
        drive(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD, 5'd0);
        step();
        chk("r0_we", 32'(ctrl_writeEnable), 32'd0);
        drive(1'b1, 5'd13, 32'hD13, 1'b1, 5'd12, 32'hC12, 5'd12);
        step();
        drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0, 5'd12);
        step();
        chk("r0_drain_reg", 32'(ctrl_writeReg), 32'd12);
        chk("r0_drain_data", data_writeReg, 32'hC12);

        // Random traffic with narrow register range to provoke collisions.
        for (int c = 0; c < 1500; c++) begin
            ctrl_reset = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
            step();
        end
        ctrl_reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sits in front of the register file's single write port and merges two writeback sources. The primary source is the in-order pipeline writeback stage, which is never stalled. The secondary source is the multi-cycle multiply/divide unit, whose results are buffered in a small FIFO and drained when the pipeline is not writing. The block also drives the register file's `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg` from registers, filters writes to `$r0`, and exposes a pending-write query for the stall logic.

## Interface
- `DEPTH`, 2: multdiv FIFO entries; power of 2, ≥2.
- `clock` in 1: single clock; all state updates on rising edge.
- `ctrl_reset` in 1: synchronous, active-high reset.
- `pipe_valid` in 1: pipeline writeback request this cycle.
- `pipe_reg` in 5: pipeline destination register.
- `pipe_data` in 32: pipeline write data.
- `md_valid` in 1: multdiv result offered.
- `md_reg` in 5: multdiv destination register.
- `md_data` in 32: multdiv result.
- `md_ready` out 1: FIFO can accept; transfer occurs when `md_valid & md_ready`.
- `q_reg` in 5: query register number.
- `q_pending` out 1: combinational; a live FIFO entry targets `q_reg`; always 0 for `q_reg`=0.
- `ctrl_writeEnable` out 1: registered write strobe to the register file.
- `ctrl_writeReg` out 5: registered write address.
- `data_writeReg` out 32: registered write data.

## Operation
- **FIFO.** Each entry holds {live, reg[4:0], data[31:0]}, with read and write pointers and `count` in 0..DEPTH. Pointers wrap modulo DEPTH.
- **`md_ready`.** `md_ready = (count != DEPTH)`. It is a function of registered state only, with no combinational path from `md_valid`.
- **Accepting a multdiv result.** On `md_valid & md_ready` with `md_reg`=0: the handshake completes and nothing is enqueued. With `md_reg`≠0: push {live=1, md_reg, md_data}.
- **Selecting a write, once per cycle:**
  - If `pipe_valid & pipe_reg`≠0, the pipeline write is selected. The FIFO is not popped.
  - Else, if `count`>0, pop the head. A live head is selected as the write. A dead head is discarded, so the output strobe is 0 that cycle.
  - Else, no write.
- **`pipe_valid` with `pipe_reg`=0** counts as idle, so the FIFO may drain in that cycle.
- **Output registers.** The selected write loads {1, reg, data} into the output registers. With no selected write they load `ctrl_writeEnable`=0, and `ctrl_writeReg`/`data_writeReg` hold their previous value.
- **Squash (program order).** A pipeline write to R≠0 clears `live` on every FIFO entry whose reg equals R in that cycle. An `md` push to R in the same cycle is pushed dead (handshake still completes). Multdiv results are always older than concurrent pipeline writebacks.
- **Simultaneous push and pop** in one cycle are allowed; `count` is unchanged. A push while full cannot occur, because `md_ready`=0.
- **Reset.** Reset clears `count`, both pointers, all live bits, `ctrl_writeEnable`, `ctrl_writeReg`, and `data_writeReg` to 0. `md_ready`=1 during the cycle after reset. An in-flight FIFO content is discarded on mid-operation reset.

## Timing
- **Pipeline write latency.** A pipeline write sampled at edge N drives the write port during cycle N+1. The register file commits it at edge N+1.
- **Multdiv write latency.** A multdiv result accepted at edge N is at the head no earlier than cycle N+1. It drives the write port in cycle N+2 at minimum, delayed by one cycle per intervening pipeline write or earlier FIFO entry.
- **Pipeline path.** Pipeline writes are never delayed or dropped, except `$r0`.
- **`q_pending`** reflects FIFO state after the most recent edge. It does not include the output register or the current-cycle `md` input.
- **Throughput.** At most one register-file write per cycle. A dead entry still costs one idle pipeline cycle.

## Test plan
- **Reset/idle.** Assert `ctrl_reset` 2 cycles with random inputs → all outputs 0, `md_ready`=1, `q_pending`=0 for every `q_reg`.
- **Pipeline latency.** `pipe_valid`=1, `pipe_reg`=5, `pipe_data`=0xDEADBEEF at edge N → cycle N+1: `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0xDEADBEEF. Cycle N+2: enable 0.
- **Priority and backpressure (DEPTH=2).** Push md→r3 (0x11) and md→r4 (0x22) while `pipe_valid`=1 with r7 for 4 cycles:
  - `md_ready`=0 after the second push.
  - `q_pending`(3)=`q_pending`(4)=1.
  - Pipeline idles → r3/0x11 then r4/0x22 written in consecutive cycles, and `md_ready` returns to 1.
- **Squash.** md→r9 (0x1) queued behind a pipeline stream, then pipeline writes r9 (0x2) → r9 final value 0x2. The dead entry produces an enable-0 cycle, and `q_pending`(9)=0 after the squash edge.
- **Simultaneous same-register.** Same-cycle md→r6 and pipe→r6 → only the pipeline write reaches the port. The md handshake completes, and `count` is unchanged after drain.
- **$r0 filtering.** md→r0 and pipe→r0 → no write strobe ever. The md handshake completes. A queued entry drains during the `pipe_reg`=0 cycle.
